send_control: RTL and testbench
===============================

Name: send_control

Overview:
- Frame-scheduling controller for the Ethernet TX path. Runs in the 125 MHz byte-clock domain.
- Repeatedly requests frame transmission from the downstream frame generator using a start_sending / busy handshake.
- Tags each frame with a segment number, a redundancy copy index (aux) and a sweep id (txid_inter).
- Sweep length and redundancy come from board switches.

Parameters:
- IFG_CYCLES, 12, idle cycles inserted after busy falls before the next request (Ethernet inter-frame gap).
- ACK_TIMEOUT, 255, cycles to wait for busy to rise after a request (used only with the optional feature).

Ports:
- clk125MHz  input  1  system clock, 125 MHz.
- RST  input  1  asynchronous active-low reset.
- switches  input  8  [3:0] segment-count code; [6:4] redundancy level; [7] pause (1 = stop issuing frames).
- busy  input  1  high while the downstream generator transmits a frame.
- segment_num  output  16  segment index of the current/next frame.
- txid_inter  output  8  sweep id; increments at the end of each full segment sweep, wraps at 255.
- aux  output  8  redundancy copy index of the current frame.
- start_sending  output  1  one-cycle request pulse to start a frame.

Behaviour:
- Reset (RST=0, asynchronous): segment_num=0, aux=0, txid_inter=0, start_sending=0, state=IDLE, gap counter=0.
- All other logic is synchronous to the rising edge of clk125MHz. Outputs are registered.
- max_count = 1 << switches[3:0], taken combinationally from the max_count_gen sub-module. Range 1..32768; segment_num runs 0..max_count-1.
- Copies per segment R = switches[6:4] + 1, range 1..8; aux runs 0..R-1.
- State machine:
  - IDLE: when switches[7]=0 and busy=0, go to REQ.
  - REQ: drive start_sending=1 for exactly one cycle, then go to WAIT_ACK.
  - WAIT_ACK: when busy=1, go to WAIT_DONE.
  - WAIT_DONE: when busy=0, load the gap counter and go to GAP.
  - GAP: count IFG_CYCLES cycles, then go to ADV.
  - ADV: update counters (one cycle). If switches[7]=1 go to IDLE, else go to REQ.
- Counter update in ADV:
  - If aux+1 >= R: aux=0 and the segment advances. Otherwise aux=aux+1.
  - Segment advance: if segment_num+1 >= max_count, then segment_num=0 and txid_inter=txid_inter+1 (mod 256). Otherwise segment_num=segment_num+1.
- Switch changes mid-run are honoured at the next ADV. The >= comparisons force an immediate wrap if the current value is out of the new range.
- segment_num, aux and txid_inter are stable from the start_sending pulse until ADV.
- Latency:
  - start_sending rises 2 cycles after reset release, when busy=0 and pause=0.
  - Request-to-request spacing = frame busy time + IFG_CYCLES + 3 cycles of overhead.
- If busy is already high in IDLE, no request is issued until busy falls.
- Pause asserted mid-frame: the frame completes, then the block parks in IDLE after ADV.
- Reset asserted mid-operation: immediate return to the reset values; any pending pulse is aborted.

Optional Feature:
- Macro SEND_CONTROL_ACK_TIMEOUT_EN.
- Defined: in WAIT_ACK, if busy has not risen within ACK_TIMEOUT cycles, go directly to GAP. Counters still advance, so a stalled generator cannot hang the controller.
- Undefined: WAIT_ACK waits indefinitely for busy.

Decomposition:
- Package send_control_pkg holds:
  - the state enum (IDLE, REQ, WAIT_ACK, WAIT_DONE, GAP, ADV);
  - the switch field bit positions;
  - the counter widths (16 and 8).
- One sub-module, max_count_gen: combinational, switches[3:0] in, 17-bit max_count out (value 1 << code).

Test Plan:
- Reset: RST=0 for 5 cycles -> all outputs 0. Release with busy=0, switches=8'b01011111 -> start_sending pulses exactly 1 cycle, 2 cycles after release, with segment_num=0, aux=0, txid_inter=0.
- Redundancy: switches=8'b01011111, busy model high for 20 cycles after each pulse -> aux steps 0..5, then segment_num=1, aux=0. Pulse spacing = 20+12+3 cycles.
- Wrap: switches=8'b00000010 (max 4, R=1) -> segment_num 0,1,2,3,0 and txid_inter increments 0->1 on the wrap.
- Pause: set switches[7]=1 during busy -> current frame finishes, counters advance once, no further start_sending. Clearing pause resumes with the next segment.
- Shrink range: segment_num=10, switches[3:0] changed to 2 -> next ADV gives segment_num=0 and txid_inter+1.
- Timeout (macro defined): busy held 0 -> new pulse every ACK_TIMEOUT+IFG_CYCLES+3 cycles, with counters advancing. Macro undefined: a single pulse, then the block stalls.

Source files
------------

// File: rtl/send_control_pkg.sv
// Shared types and constants for the TX frame scheduler: FSM states, switch
// field positions and counter widths.
package send_control_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_ACK,
    WAIT_DONE,
    GAP,
    ADV
  } state_t;

  localparam int SW_CODE_LSB = 0;
  localparam int SW_CODE_MSB = 3;
  localparam int SW_RED_LSB  = 4;
  localparam int SW_RED_MSB  = 6;
  localparam int SW_PAUSE    = 7;

  localparam int SEG_W = 16;
  localparam int ID_W  = 8;
  localparam int MAX_W = SEG_W + 1;

endpackage

// File: rtl/send_control_max_count_gen.sv
// Segment sweep length decoder: max_count = 1 << code (1..32768).
module max_count_gen
  import send_control_pkg::*;
(
  input  logic [3:0]       code,
  output logic [MAX_W-1:0] max_count
);

  assign max_count = MAX_W'(1) << code;

endmodule

// File: rtl/send_control.sv
// Frame-scheduling controller for the Ethernet TX byte-clock domain.
// Optional build macro SEND_CONTROL_ACK_TIMEOUT_EN: abandon a request whose
// busy acknowledge never arrives after ACK_TIMEOUT cycles.
module send_control
  import send_control_pkg::*;
#(
  parameter int IFG_CYCLES  = 12,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk125MHz,
  input  logic             RST,
  input  logic [7:0]       switches,
  input  logic             busy,
  output logic [SEG_W-1:0] segment_num,
  output logic [ID_W-1:0]  txid_inter,
  output logic [ID_W-1:0]  aux,
  output logic             start_sending
);

  localparam int GAP_W = $clog2(IFG_CYCLES + 1);

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [MAX_W-1:0] max_count;
  logic             pause;
  logic             aux_wrap, seg_wrap;

  max_count_gen u_max_count_gen (
    .code      (switches[SW_CODE_MSB:SW_CODE_LSB]),
    .max_count (max_count)
  );

  assign pause = switches[SW_PAUSE];

  // >= rather than == so a range shrunk below the current value wraps at once
  assign aux_wrap = (9'(aux) + 9'd1) >= (9'(switches[SW_RED_MSB:SW_RED_LSB]) + 9'd1);
  assign seg_wrap = (MAX_W'(segment_num) + MAX_W'(1)) >= max_count;

`ifdef SEND_CONTROL_ACK_TIMEOUT_EN
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  logic [ACK_W-1:0] ack_cnt;
  logic             ack_expired;

  assign ack_expired = (ack_cnt == ACK_W'(ACK_TIMEOUT));

  always_ff @(posedge clk125MHz or negedge RST) begin
    if (!RST)                                  ack_cnt <= '0;
    else if (state != WAIT_ACK)                ack_cnt <= '0;
    else if (!ack_expired)                     ack_cnt <= ack_cnt + 1'b1;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!pause && !busy) state_nxt = REQ;
      REQ:       state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (busy) state_nxt = WAIT_DONE;
`ifdef SEND_CONTROL_ACK_TIMEOUT_EN
        else if (ack_expired) state_nxt = GAP;
`endif
      end
      WAIT_DONE: if (!busy) state_nxt = GAP;
      GAP:       if (gap_cnt == '0) state_nxt = ADV;
      ADV:       state_nxt = pause ? IDLE : REQ;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk125MHz or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      start_sending <= 1'b0;
      segment_num   <= '0;
      aux           <= '0;
      txid_inter    <= '0;
    end else begin
      state         <= state_nxt;
      start_sending <= (state == REQ);

      // GAP lasts exactly IFG_CYCLES cycles: load N-1, leave on zero
      if (state != GAP && state_nxt == GAP)
        gap_cnt <= GAP_W'(IFG_CYCLES - 1);
      else if (state == GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;

      if (state == ADV) begin
        if (aux_wrap) begin
          aux <= '0;
          if (seg_wrap) begin
            segment_num <= '0;
            txid_inter  <= txid_inter + 1'b1;
          end else begin
            segment_num <= segment_num + 1'b1;
          end
        end else begin
          aux <= aux + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_send_control.sv
// Randomized self-checking bench for send_control with a frame-level model.
module tb_send_control;

  localparam int IFG = 12;
  localparam int ACK_TO = 255;
  localparam int OVH = IFG + 3;

  logic        clk125MHz = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  switches = 8'h5F;
  logic        busy = 1'b0;
  logic [15:0] segment_num;
  logic [7:0]  txid_inter;
  logic [7:0]  aux;
  logic        start_sending;

  send_control #(.IFG_CYCLES(IFG), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk125MHz     (clk125MHz),
    .RST           (RST),
    .switches      (switches),
    .busy          (busy),
    .segment_num   (segment_num),
    .txid_inter    (txid_inter),
    .aux           (aux),
    .start_sending (start_sending)
  );

  always #4 clk125MHz = ~clk125MHz;

  int cyc = 0;
  always @(posedge clk125MHz) cyc++;

  int n_chk = 0, n_pass = 0;
  int m_seg = 0, m_aux = 0, m_id = 0;
  int last_pulse = 0, last_b = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One frame's worth of bookkeeping: advance copy index, then segment, then sweep.
  task automatic model_adv(input logic [7:0] sw);
    int copies, span;
    copies = int'(sw[6:4]) + 1;
    span   = 1 << sw[3:0];
    m_aux++;
    if (m_aux >= copies) begin
      m_aux = 0;
      m_seg++;
      if (m_seg >= span) begin
        m_seg = 0;
        m_id  = (m_id + 1) % 256;
      end
    end
  endtask

  task automatic chk_tags(input string tag);
    chk({tag, "_seg"}, int'(segment_num), m_seg);
    chk({tag, "_aux"}, int'(aux), m_aux);
    chk({tag, "_id"}, int'(txid_inter), m_id);
  endtask

  task automatic wait_pulse(input int exp_gap);
    int n = 0;
    bit found = 0;
    while (!found && n < 1000) begin
      @(posedge clk125MHz); #1;
      n++;
      if (start_sending) found = 1;
    end
    if (!found) chk("pulse_wait", 0, 1);
    else begin
      if (exp_gap > 0) chk("spacing", cyc - last_pulse, exp_gap);
      last_pulse = cyc;
      chk_tags("frame");
    end
  endtask

  // Called just after a pulse is seen: generator busy for b cycles, switches updated mid-frame.
  task automatic serve(input int b, input logic [7:0] sw);
    busy = 1'b1;
    switches = sw;
    @(posedge clk125MHz); #1;
    chk("pulse_width", int'(start_sending), 0);
    repeat (b - 1) begin
      @(posedge clk125MHz); #1;
    end
    busy = 1'b0;
    model_adv(sw);
    last_b = b;
  endtask

  task automatic expect_quiet(input int n, input string tag);
    int pulses = 0;
    repeat (n) begin
      @(posedge clk125MHz); #1;
      if (start_sending) pulses++;
    end
    chk(tag, pulses, 0);
  endtask

  initial begin
    int b;
    logic [7:0] sw;
    bit hit;

    // reset and first-request latency
    repeat (5) @(posedge clk125MHz);
    #1;
    chk("rst_start", int'(start_sending), 0);
    chk_tags("rst");
    RST = 1'b1;
    @(posedge clk125MHz); #1;
    chk("lat_early", int'(start_sending), 0);
    @(posedge clk125MHz); #1;
    chk("lat_pulse", int'(start_sending), 1);
    last_pulse = cyc;
    chk_tags("first");
    serve(20, 8'h5F);

    // six copies per segment, fixed 20-cycle frames
    for (int i = 0; i < 7; i++) begin
      wait_pulse(20 + OVH);
      serve(20, 8'h5F);
    end

    // four segments, single copy: sweep wraps and txid bumps
    for (int i = 0; i < 7; i++) begin
      wait_pulse(last_b + OVH);
      serve(5, 8'h02);
    end

    // pause mid-frame: frame completes, then silence
    wait_pulse(last_b + OVH);
    serve(8, 8'h82);
    expect_quiet(60, "pause_quiet");
    chk_tags("paused");
    switches = 8'h02;
    wait_pulse(-1);
    serve(8, 8'h04);

    // run up to segment 10 of a 16-long sweep, then shrink to 4
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      wait_pulse(last_b + OVH);
      if (m_seg == 10) begin
        serve(8, 8'h02);
        hit = 1;
      end else serve(8, 8'h04);
    end
    chk("shrink_reached", int'(hit), 1);
    wait_pulse(last_b + OVH);
    chk("shrink_seg", int'(segment_num), 0);
    serve(6, 8'h02);

    // randomized frame lengths and switch settings
    for (int i = 0; i < 25; i++) begin
      wait_pulse(last_b + OVH);
      b  = int'($urandom_range(1, 40));
      sw = {1'b0, 3'($urandom), 4'($urandom_range(0, 5))};
      serve(b, sw);
    end

    // generator never acknowledges
    wait_pulse(last_b + OVH);
`ifdef SEND_CONTROL_ACK_TIMEOUT_EN
    model_adv(switches);
    wait_pulse(ACK_TO + OVH);
`else
    expect_quiet(400, "stall_quiet");
    chk_tags("stall");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
